// File: rtl/multi_clock_divider_pkg.sv
// Shared constants, channel state encoding and a rate helper for the
// multi-channel clock divider.
package multi_clock_divider_pkg;

  localparam int CLK_HZ               = 50000000;
  localparam int DEFAULT_HALF_50M_2HZ = 12500000;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Half-period in board-clock cycles for a requested output frequency.
  function automatic int half_for_hz(input int hz);
    return CLK_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Configuration bus for the multi-channel clock divider.
// Handshake: cfg_wr is a single-cycle strobe with no backpressure. Every
// strobe is answered exactly one cycle later by either a one-cycle cfg_ack
// (channel exists, shadow loaded) or a one-cycle cfg_err (channel out of range,
// nothing changed). The master may issue a new strobe every cycle.
interface multi_clock_divider_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 26
);
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (output cfg_wr, cfg_ch, cfg_half, input cfg_ack, cfg_err);
  modport slave  (input cfg_wr, cfg_ch, cfg_half, output cfg_ack, cfg_err);
endinterface

// File: rtl/divider_channel.sv
// One divider channel: counter, active/shadow half-period with pending flag,
// square-wave level and rising-edge tick. A new half-period is only adopted
// at a toggle boundary (or immediately when idle) so no runt pulse appears.
module divider_channel
  import multi_clock_divider_pkg::*;
#(
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = DEFAULT_HALF_50M_2HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             level,
  output logic             tick
);

  ch_state_e        state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             level_q, level_d;
  logic             tick_q, tick_d;
  logic             apply;
  logic [CNT_W-1:0] eff_m1;
  logic             wrap;

  // The run enable alone selects the mode; idle forces everything to zero.
  assign state  = en ? CH_RUN : CH_IDLE;
  // half = 0 behaves as 1, so the terminal count is clamped at zero.
  assign eff_m1 = (half_q == '0) ? '0 : half_q - 1'b1;
  assign wrap   = (cnt_q == eff_m1);

  // Next-state: counting, toggling, shadow apply and config capture.
  always_comb begin
    cnt_d    = cnt_q;
    half_d   = half_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    level_d  = level_q;
    tick_d   = 1'b0;
    apply    = 1'b0;
    case (state)
      CH_RUN: begin
        if (sync) begin
          cnt_d   = '0;
          level_d = 1'b0;
          apply   = 1'b1;
        end else if (wrap) begin
          cnt_d   = '0;
          level_d = ~level_q;
          tick_d  = ~level_q;
          apply   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        level_d = 1'b0;
        apply   = 1'b1;
      end
    endcase
    // Apply uses the shadow from before this cycle's write, so a write that
    // lands on a boundary waits for the following one.
    if (apply && pend_q) begin
      half_d = shadow_q;
      pend_d = 1'b0;
    end
    if (wr) begin
      shadow_d = wr_half;
      pend_d   = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      half_q   <= CNT_W'(DEFAULT_HALF);
      shadow_q <= CNT_W'(DEFAULT_HALF);
      pend_q   <= 1'b0;
      level_q  <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      level_q  <= level_d;
      tick_q   <= tick_d;
    end
  end

  assign level = level_q;
  assign tick  = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider. Decodes config writes, answers them
// with ack/err pulses and fans the optional phase-sync out to every channel.
// Optional feature macro: MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN adds the
// phase_sync input that restarts all running channels in phase.
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = DEFAULT_HALF_50M_2HZ,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  inClock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_en,
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
  input  logic                  phase_sync,
`endif
  multi_clock_divider_if.slave  cfg,
  output logic [NUM_CH-1:0]     out_level,
  output logic [NUM_CH-1:0]     tick
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic              cfg_valid;
  logic [NUM_CH-1:0] wr_sel;
  logic              sync;
  logic              ack_q;
  logic              err_q;

`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
  assign sync = phase_sync;
`else
  assign sync = 1'b0;
`endif

  assign cfg_valid = ({1'b0, cfg.cfg_ch} < NUM_CH_V);

  // One-hot write select; an out-of-range channel matches nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i));
    end
  end

  // Write response pulses, one cycle after the strobe.
  always_ff @(posedge inClock) begin
    if (reset) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= cfg.cfg_wr && cfg_valid;
      err_q <= cfg.cfg_wr && !cfg_valid;
    end
  end

  assign cfg.cfg_ack = ack_q;
  assign cfg.cfg_err = err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    divider_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk     (inClock),
      .rst     (reset),
      .en      (ch_en[gi]),
      .sync    (sync),
      .wr      (wr_sel[gi]),
      .wr_half (cfg.cfg_half),
      .level   (out_level[gi]),
      .tick    (tick[gi])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: directed scenarios followed by random
// enables/writes, compared every cycle against a time-based reference model
// (each channel toggles when the cycles since its last boundary reach
// max(half,1)).
module tb_multi_clock_divider;
  localparam int NUM  = 3;
  localparam int CNTW = 8;
  localparam int CW   = 2;
  localparam int DEF  = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [NUM-1:0] ch_en;
  logic           phase_sync;
  logic [NUM-1:0] out_level;
  logic [NUM-1:0] tick;

  multi_clock_divider_if #(.CH_W(CW), .CNT_W(CNTW)) bus ();

  multi_clock_divider #(
    .NUM_CH(NUM), .CNT_W(CNTW), .DEFAULT_HALF(DEF), .CH_W(CW)
  ) dut (
    .inClock   (clk),
    .reset     (reset),
    .ch_en     (ch_en),
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
    .phase_sync(phase_sync),
`endif
    .cfg       (bus.slave),
    .out_level (out_level),
    .tick      (tick)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model state
  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;
  int     m_half[NUM];
  int     m_shadow[NUM];
  bit     m_pend[NUM];
  bit     m_level[NUM];
  bit     m_tick[NUM];
  longint m_last[NUM];
  bit     m_ack, m_err;

  function automatic int eff(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Advance the model by one clock edge using the inputs held stable across it.
  task automatic model_edge();
    bit s;
    cyc++;
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
    s = phase_sync;
`else
    s = 1'b0;
`endif
    if (reset) begin
      for (int i = 0; i < NUM; i++) begin
        m_half[i] = DEF; m_shadow[i] = DEF; m_pend[i] = 0;
        m_level[i] = 0; m_tick[i] = 0; m_last[i] = cyc;
      end
      m_ack = 0; m_err = 0;
    end else begin
      m_ack = bus.cfg_wr && (int'(bus.cfg_ch) < NUM);
      m_err = bus.cfg_wr && (int'(bus.cfg_ch) >= NUM);
      for (int i = 0; i < NUM; i++) begin
        bit boundary;
        boundary = 0;
        m_tick[i] = 0;
        if (!ch_en[i] || s) begin
          m_level[i] = 0; m_last[i] = cyc; boundary = 1;
        end else if (cyc - m_last[i] == longint'(eff(m_half[i]))) begin
          m_level[i] = !m_level[i]; m_tick[i] = m_level[i];
          m_last[i] = cyc; boundary = 1;
        end
        if (boundary && m_pend[i]) begin
          m_half[i] = m_shadow[i]; m_pend[i] = 0;
        end
        if (bus.cfg_wr && int'(bus.cfg_ch) == i) begin
          m_shadow[i] = int'(bus.cfg_half); m_pend[i] = 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] vec(input bit v[NUM]);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NUM; i++) r[i] = v[i];
    return r;
  endfunction

  // driver: one clock, then compare all outputs just after the edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("out_level", 32'(out_level), vec(m_level));
    check("tick", 32'(tick), vec(m_tick));
    check("cfg_ack", 32'(bus.cfg_ack), 32'(m_ack));
    check("cfg_err", 32'(bus.cfg_err), 32'(m_err));
  endtask

  task automatic write(input int ch, input int half);
    bus.cfg_wr = 1'b1; bus.cfg_ch = CW'(ch); bus.cfg_half = CNTW'(half);
    step();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b1; ch_en = '0; phase_sync = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_half = '0;
    step();
    // reset and a write in the same cycle: the write must be ignored
    bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_half = 8'd2;
    step();
    reset = 1'b0; bus.cfg_wr = 1'b0;
    run(2);

    // channel 0 at the default half-period
    ch_en[0] = 1'b1;
    run(25);

    // program idle channel 1, then enable it
    write(1, 3);
    run(2);
    ch_en[1] = 1'b1;
    run(15);

    // retime channel 0 mid half-period
    run(2);
    write(0, 2);
    run(16);

    // half = 0 on channel 2
    write(2, 0);
    ch_en[2] = 1'b1;
    run(8);

    // out-of-range channel
    write(3, 1);
    run(3);

    // back-to-back writes to the same channel
    write(1, 4);
    write(1, 1);
    run(12);

    // drop channel 0 while its output is high
    for (int k = 0; k < 40 && !m_level[0]; k++) step();
    check("wait_ch0_high", 32'(m_level[0]), 32'd1);
    ch_en[0] = 1'b0;
    step();
    run(3);
    ch_en[0] = 1'b1;

`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
    write(0, 3);
    write(1, 3);
    write(2, 3);
    run(5);
    phase_sync = 1'b1;
    step();
    phase_sync = 1'b0;
    run(12);
`endif

    // randomized enables, writes and (when present) sync pulses
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(19, 0) == 0) ch_en[$urandom_range(NUM - 1, 0)] ^= 1'b1;
      bus.cfg_wr = ($urandom_range(3, 0) == 0);
      bus.cfg_ch = CW'($urandom_range(3, 0));
      bus.cfg_half = CNTW'($urandom_range(6, 0));
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
      phase_sync = ($urandom_range(39, 0) == 0);
`endif
      step();
    end
    bus.cfg_wr = 1'b0; phase_sync = 1'b0;
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- N-channel programmable clock divider; successor to the fixed single-output 2 Hz divider.
- Each channel produces a square wave plus a one-cycle tick aligned to its rising edge.
- Half-period is runtime-programmable per channel through a single-cycle config write.
- Sits between the 50 MHz board clock and the tail-light sequencer / blink logic; provides multiple blink and sequence rates from one block.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 26, width of the half-period and counter registers.
- DEFAULT_HALF, 12500000, reset half-period in inClock cycles (50 MHz to 2 Hz).
- CH_W, $clog2(NUM_CH) with a minimum of 1, width of the channel-select field.

Ports:
- inClock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset; sampled on posedge inClock only.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_wr  in  1  one-cycle config write strobe.
- cfg_ch  in  CH_W  target channel for the write.
- cfg_half  in  CNT_W  new half-period in cycles.
- cfg_ack  out  1  one-cycle pulse, accepted write.
- cfg_err  out  1  one-cycle pulse, rejected write (cfg_ch >= NUM_CH).
- out_level  out  NUM_CH  divided square waves.
- tick  out  NUM_CH  one-cycle pulse per rising edge of out_level.

Behaviour:
- Reset (synchronous, wins over every other input in the same cycle): half, shadow = DEFAULT_HALF; counter = 0; pend = 0; out_level, tick, cfg_ack, cfg_err = 0.
- Per-channel state: IDLE (ch_en=0) and RUN (ch_en=1).
- IDLE: counter = 0 and out_level = 0, both forced every cycle.
- IDLE to RUN: counting starts on the first cycle ch_en is sampled high. After eff cycles in RUN, out_level rises and tick pulses on the same edge.
- Effective half-period: eff = max(half, 1). half = 0 behaves as 1, i.e. a toggle every cycle (period 2 cycles).
- RUN counting: counter increments each cycle. When counter == eff-1, counter goes to 0 and out_level toggles. Output period is exactly 2*eff cycles, 50% duty.
- tick[i] = 1 for exactly one cycle, registered, coincident with the cycle out_level[i] goes 0 to 1. It is never asserted on the falling toggle.
- RUN to IDLE (ch_en drops): next cycle out_level = 0, counter = 0, tick = 0. No partial tick.
- Config write: cfg_wr with a valid cfg_ch loads shadow[cfg_ch] = cfg_half and sets pend, and pulses cfg_ack on the next cycle.
- Config write with an invalid cfg_ch: no state change; cfg_err pulses on the next cycle.
- Shadow apply rule (glitch-free retiming):
  - IDLE channel: applied on the next cycle.
  - RUN channel: applied at the next toggle boundary (the cycle counter wraps to 0), then pend clears.
- Back-to-back writes to the same channel: the last write wins; only one pend is held.
- Write landing in the same cycle as a toggle: the old value is used for that toggle; the new value applies at the following boundary.
- Counter never exceeds eff-1. No wrap-around hazard, since the comparison is against the active half only.
- Channels are fully independent; simultaneous toggles on all channels are legal.

Optional Feature:
- Macro: MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN.
- Enabled:
  - Adds input port phase_sync (1 bit).
  - When sampled high, every RUN channel sets counter = 0 and out_level = 0 and applies any pending shadow. No tick in that cycle.
  - This aligns all blink rates to a common phase.
  - Reset has priority over phase_sync, and phase_sync has priority over a toggle in the same cycle.
- Disabled: the port is absent and channels free-run independently.

Decomposition:
- Package multi_clock_divider_pkg holds:
  - DEFAULT_HALF_50M_2HZ = 12500000;
  - CLK_HZ = 50000000;
  - a function half_for_hz(hz) = CLK_HZ/(2*hz).
- Sub-module divider_channel: one channel's counter, half/shadow/pend registers, level and tick. It is instantiated NUM_CH times by a generate loop.
- The top level contains only cfg_ch decode, the cfg_ack/cfg_err registers, and sync fan-out.

Test Plan:
- Reset, then ch_en[0]=1 with NUM_CH=4, DEFAULT_HALF=5 -> out_level[0] rises after 5 cycles and period = 10 cycles; tick[0] high 1 cycle per period; the other channels stay 0.
- cfg_wr with cfg_ch=1, cfg_half=3 while ch1 is IDLE, then enable -> cfg_ack 1 cycle after the write; period 6 cycles; cfg_err stays 0.
- Ch0 running with half=5, cfg_half=2 written mid-half-period -> the current half completes at 5 cycles; subsequent halves are 2 cycles; no runt pulse.
- cfg_half=0 on ch2 -> out_level toggles every cycle; tick on every second cycle.
- NUM_CH=3, cfg_ch=3 -> cfg_err pulse, cfg_ack=0, no channel changes. A separate case with reset and cfg_wr in the same cycle -> the write is ignored and all defaults hold.
- ch_en dropped mid-high-phase -> out_level = 0 next cycle. With MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN, a phase_sync pulse -> all running channels restart in phase and their first ticks coincide for equal half values.
